dm_mem_mh: RTL and testbench
============================

Name: dm_mem_mh

Overview:
Multi-hart debug memory for the debug module.
- Serves the core-side debug memory window: halted/going/resuming/exception mailboxes, whereto, abstract-command words, program buffer, data registers, per-hart flags; forwards ROM reads.
- Generalises the single-hart version to NrHarts harts and a 32- or 64-bit bus.
- Adds an explicit command/resume state machine with full cmderror reporting.

Parameters:
NrHarts, 4, number of harts tracked (1..32)
BusWidth, 32, core bus width, 32 or 64
ProgBufSize, 8, program buffer words (even, ≥2)
DataCount, 2, data registers (≥1)
AbsCmdWords, 10, abstract-command words placed below the program buffer

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ndmreset_i  in  1  non-debug reset; clears hart state
hartsel_i  in  20  selected hart
haltreq_i  in  1  halt request for hartsel_i
debug_req_o  out  NrHarts  one-hot halt request, bit hartsel_i = haltreq_i
resumereq_i  in  1  resume request for hartsel_i
clear_resumeack_i  in  1  clears resuming of hartsel_i
halted_o  out  NrHarts  per-hart halted
resuming_o  out  NrHarts  per-hart resuming (resumeack)
progbuf_i  in  32*ProgBufSize  program buffer, flattened
abscmd_i  in  32*AbsCmdWords  generated abstract-command words
cmd_valid_i  in  1  abstract command write strobe
cmd_transfer_i, cmd_postexec_i, cmd_unsupported_i  in  1 each  decoded command fields
cmdbusy_o  out  1  command executing
cmderror_valid_o  out  1  one-cycle error pulse
cmderror_o  out  3  1 busy, 2 unsupported, 3 exception, 4 halt/resume
data_i  in  32*DataCount  data registers from DM CSRs
data_o  out  32*DataCount  data registers with core writes merged
data_valid_o  out  1  core wrote data this cycle
req_i, we_i  in  1 each  memory strobe, write enable
addr_i  in  BusWidth  address; offset = addr_i[11:0]
wdata_i  in  BusWidth  write data
be_i  in  BusWidth/8  byte enables
rom_rdata_i  in  64  debug ROM word, valid one cycle after req_i
rdata_o  out  BusWidth  read data

Behaviour:
Reset values
- Reset is rst_ni, asynchronous, active-low, on clock clk_i.
- All state is zero at reset: halted, resuming, rdata register, FSM = IDLE.
- cmdbusy_o = 0, cmderror_valid_o = 0, data_valid_o = 0.

Address map (12-bit offset)
- Mailboxes: Halted 0x100, Going 0x108, Resuming 0x110, Exception 0x118.
- WhereTo 0x300.
- Data: 0x380 .. 0x380+4*DataCount-1.
- ProgBuf: 0x380-4*ProgBufSize upward.
- AbsCmd: ProgBuf base − 4*AbsCmdWords upward.
- Flags: 0x400-0x7FF, one byte per hart at 0x400+hart.
- ROM: ≥0x800.

Mailbox writes (wdata_i[4:0] carries the hart ID)
- Halted write: halted[id] = 1.
- Resuming write: halted[id] = 0, resuming[id] = 1.
- IDs ≥ NrHarts are ignored.
- clear_resumeack_i: resuming[hartsel] = 0.
- If clear_resumeack_i and a Resuming write hit the same hart in the same cycle, the set wins.
- ndmreset_i clears all halted/resuming and forces IDLE; it has priority over every other event.

Reads
- Latency is one cycle; rdata_o is registered from the request cycle.
- ROM region returns rom_rdata_i.
- Unmapped offsets return 0.
- Writes return no data.
- BusWidth 32: rdata_o is the 64-bit word half selected by the registered addr_i[2].
- BusWidth 64: rdata_o is the whole word.

Data writes
- Byte-merged into data_o per be_i in the same cycle, combinational.
- data_valid_o is high for that cycle.
- Otherwise data_o = data_i.

Flags byte for hart h
- bit0 go = (h == hartsel and FSM = GO).
- bit1 resume = (h == hartsel and FSM = RESUME).
- All other bits are 0.

WhereTo read returns JAL x0:
- FSM = RESUME: jump to 0x808.
- Command executing, postexec and not transfer: jump to ProgBuf base.
- Otherwise: jump to AbsCmd base.

FSM {IDLE, GO, EXEC, RESUME}:
- IDLE + cmd_valid_i:
  - hartsel not halted or ≥ NrHarts → error 4.
  - Else unsupported → error 2.
  - Else → GO.
- IDLE + resumereq_i with halted[hartsel] → RESUME.
- If cmd_valid_i and resumereq_i arrive together in IDLE, the command wins.
- GO + Going write → EXEC.
- EXEC + Halted write from hartsel → IDLE.
- EXEC + Exception write → IDLE, error 3.
- RESUME + Resuming write from hartsel → IDLE.
- cmd_valid_i while in GO or EXEC → error 1; state unchanged.
- cmdbusy_o = 1 in GO and EXEC.
- cmderror_valid_o is a registered one-cycle pulse, one cycle after the cause.

Test Plan:
- Reset then read Flags 0x400 → rdata_o = 0 next cycle; halted_o = 0, cmdbusy_o = 0.
- Write Halted, wdata = 2 → halted_o = 4'b0100. Then hartsel = 2, cmd_valid_i (transfer) → cmdbusy_o = 1, flags 0x402 = 0x01, WhereTo = JAL to AbsCmd base. Write Going, then Halted(2) → cmdbusy_o = 0, no error.
- With hart 1 halted, hartsel = 1, resumereq_i → WhereTo = JAL x0 to 0x808 (encoding 0x5080006F). Resuming(1) write → halted_o[1] = 0, resuming_o[1] = 1. clear_resumeack_i → resuming_o[1] = 0.
- cmd_valid_i with hart not halted → cmderror 4 pulse. cmd_valid_i during EXEC → cmderror 1. cmd_unsupported_i = 1 → cmderror 2. Exception write during EXEC → cmderror 3, FSM IDLE.
- Data write to 0x384 with be = 4'b0011, wdata = 0xAABBCCDD, data_i[1] = 0x11223344 → data_o[1] = 0x1122CCDD, data_valid_o = 1 that cycle.
- BusWidth = 64 build: read ProgBuf base → rdata_o = {progbuf[1], progbuf[0]}. ndmreset_i during EXEC → halted_o = 0, cmdbusy_o = 0 next cycle.

Source files
------------

// File: rtl/dm_mem_mh.sv
// Multi-hart debug memory: mailboxes, whereto, abstract command,
// program buffer, data, per-hart flags and ROM forwarding.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   ndmreset_i              clears all hart state, forces idle
//   hartsel_i               selected hart
//   haltreq_i/debug_req_o   one-hot halt request to selected hart
//   resumereq_i             resume request for selected hart
//   clear_resumeack_i       clears resuming of selected hart
//   halted_o, resuming_o    per-hart status
//   progbuf_i, abscmd_i     program buffer / abstract command words
//   cmd_*_i                 abstract command strobe and fields
//   cmdbusy_o               command in progress
//   cmderror_valid_o/_o     registered one-cycle error pulse and code
//   data_i/data_o           data registers, core writes merged
//   data_valid_o            core wrote data this cycle
//   req_i, we_i, addr_i,
//   wdata_i, be_i, rdata_o  core-side memory port
//   rom_rdata_i             debug ROM word (one cycle after req_i)
module dm_mem_mh #(
  parameter int unsigned NrHarts     = 4,
  parameter int unsigned BusWidth    = 32,
  parameter int unsigned ProgBufSize = 8,
  parameter int unsigned DataCount   = 2,
  parameter int unsigned AbsCmdWords = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ndmreset_i,
  input  logic [19:0]               hartsel_i,
  input  logic                      haltreq_i,
  output logic [NrHarts-1:0]        debug_req_o,
  input  logic                      resumereq_i,
  input  logic                      clear_resumeack_i,
  output logic [NrHarts-1:0]        halted_o,
  output logic [NrHarts-1:0]        resuming_o,
  input  logic [32*ProgBufSize-1:0] progbuf_i,
  input  logic [32*AbsCmdWords-1:0] abscmd_i,
  input  logic                      cmd_valid_i,
  input  logic                      cmd_transfer_i,
  input  logic                      cmd_postexec_i,
  input  logic                      cmd_unsupported_i,
  output logic                      cmdbusy_o,
  output logic                      cmderror_valid_o,
  output logic [2:0]                cmderror_o,
  input  logic [32*DataCount-1:0]   data_i,
  output logic [32*DataCount-1:0]   data_o,
  output logic                      data_valid_o,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [BusWidth-1:0]       addr_i,
  input  logic [BusWidth-1:0]       wdata_i,
  input  logic [BusWidth/8-1:0]     be_i,
  input  logic [63:0]               rom_rdata_i,
  output logic [BusWidth-1:0]       rdata_o
);

  localparam int DataBase = 'h380;
  localparam int PbBase   = DataBase - 4 * ProgBufSize;
  localparam int AbsBase  = PbBase - 4 * AbsCmdWords;
  localparam int DataEnd  = DataBase + 4 * DataCount;
  localparam int BeW      = BusWidth / 8;

  typedef enum logic [1:0] {
    Idle, Go, Exec, Resume
  } state_e;

  state_e              state_q;
  logic [NrHarts-1:0]  halted_q, resuming_q;
  logic [NrHarts-1:0]  halted_d, resuming_d;
  logic [NrHarts-1:0]  sel_oh, id_oh;
  logic [2:0]          err_q;
  logic                err_valid_q;
  logic                transfer_q, postexec_q;
  logic [63:0]         rdata_q, rd64, word64;
  logic                rom_q, hi_q;
  logic [11:0]         off;
  logic [4:0]          id;
  logic                wr, busy, sel_halted, id_is_sel;
  logic                halted_wr, going_wr;
  logic                resuming_wr, except_wr;
  logic [31:0]         wt;
  logic                unused_bits;

  assign off = addr_i[11:0];
  assign id  = wdata_i[4:0];
  assign wr  = req_i & we_i;

  assign halted_wr   = wr && off == 12'h100;
  assign going_wr    = wr && off == 12'h108;
  assign resuming_wr = wr && off == 12'h110;
  assign except_wr   = wr && off == 12'h118;
  assign id_is_sel   = {15'd0, id} == hartsel_i;

  assign busy = state_q == Go || state_q == Exec;

  assign halted_o         = halted_q;
  assign resuming_o       = resuming_q;
  assign cmdbusy_o        = busy;
  assign cmderror_valid_o = err_valid_q;
  assign cmderror_o       = err_q;

  assign unused_bits = ^{addr_i[BusWidth-1:12], hi_q};

  function automatic logic [31:0] jal(input int tgt);
    logic [20:0] imm;
    imm = 21'(tgt - 'h300);
    return {imm[20], imm[10:1], imm[11],
            imm[19:12], 5'd0, 7'h6f};
  endfunction

  always_comb begin
    sel_oh = '0;
    id_oh  = '0;
    for (int h = 0; h < NrHarts; h++) begin
      sel_oh[h] = hartsel_i == 20'(h);
      id_oh[h]  = id == 5'(h);
    end
    sel_halted  = |(halted_q & sel_oh);
    debug_req_o = haltreq_i ? sel_oh : '0;
  end

  // A resuming write beats a same-cycle resumeack clear.
  always_comb begin
    halted_d   = halted_q;
    resuming_d = resuming_q;
    if (halted_wr)
      halted_d = halted_d | id_oh;
    if (resuming_wr)
      halted_d = halted_d & ~id_oh;
    if (clear_resumeack_i)
      resuming_d = resuming_d & ~sel_oh;
    if (resuming_wr)
      resuming_d = resuming_d | id_oh;
  end

  always_comb begin
    if (state_q == Resume)
      wt = jal('h808);
    else if (busy && postexec_q && !transfer_q)
      wt = jal(PbBase);
    else
      wt = jal(AbsBase);
  end

  // Build the 64-bit word around the access, 32 bits at a time.
  always_comb begin : p_rd
    int          a;
    logic [31:0] w32;
    rd64 = '0;
    a    = 0;
    w32  = '0;
    for (int w = 0; w < 2; w++) begin
      a   = int'({20'd0, off[11:3], 3'd0}) + 4 * w;
      w32 = '0;
      if (a == 'h300)
        w32 = wt;
      for (int i = 0; i < AbsCmdWords; i++)
        if (a == AbsBase + 4 * i)
          w32 = abscmd_i[32*i +: 32];
      for (int i = 0; i < ProgBufSize; i++)
        if (a == PbBase + 4 * i)
          w32 = progbuf_i[32*i +: 32];
      for (int i = 0; i < DataCount; i++)
        if (a == DataBase + 4 * i)
          w32 = data_i[32*i +: 32];
      for (int h = 0; h < NrHarts; h++)
        if (a == 'h400 + 4 * (h / 4))
          w32[8*(h%4) +: 8] = {
            6'd0,
            sel_oh[h] && state_q == Resume,
            sel_oh[h] && state_q == Go};
      rd64[32*w +: 32] = w32;
    end
  end

  always_comb begin : p_data
    int wbase;
    wbase  = int'({20'd0, off}) & ~(BeW - 1);
    data_o = data_i;
    for (int d = 0; d < 4 * DataCount; d++)
      for (int k = 0; k < BeW; k++)
        if (wr && be_i[k] && wbase + k == DataBase + d)
          data_o[8*d +: 8] = wdata_i[8*k +: 8];
    data_valid_o = wr && wbase >= DataBase
                   && wbase < DataEnd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      halted_q    <= '0;
      resuming_q  <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      transfer_q  <= 1'b0;
      postexec_q  <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      if (ndmreset_i) begin
        state_q    <= Idle;
        halted_q   <= '0;
        resuming_q <= '0;
      end else begin
        halted_q   <= halted_d;
        resuming_q <= resuming_d;
        case (state_q)
          Idle: begin
            if (cmd_valid_i) begin
              if (!sel_halted) begin
                err_valid_q <= 1'b1;
                err_q       <= 3'd4;
              end else if (cmd_unsupported_i) begin
                err_valid_q <= 1'b1;
                err_q       <= 3'd2;
              end else begin
                state_q    <= Go;
                transfer_q <= cmd_transfer_i;
                postexec_q <= cmd_postexec_i;
              end
            end else if (resumereq_i && sel_halted) begin
              state_q <= Resume;
            end
          end
          Go: begin
            if (cmd_valid_i) begin
              err_valid_q <= 1'b1;
              err_q       <= 3'd1;
            end else if (going_wr) begin
              state_q <= Exec;
            end
          end
          Exec: begin
            if (cmd_valid_i) begin
              err_valid_q <= 1'b1;
              err_q       <= 3'd1;
            end else if (except_wr) begin
              state_q     <= Idle;
              err_valid_q <= 1'b1;
              err_q       <= 3'd3;
            end else if (halted_wr && id_is_sel) begin
              state_q <= Idle;
            end
          end
          Resume: begin
            if (resuming_wr && id_is_sel)
              state_q <= Idle;
          end
          default: state_q <= Idle;
        endcase
      end
    end
  end

  // Writes return zero; ROM data arrives a cycle late,
  // so only the selection is registered for it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      rom_q   <= 1'b0;
      hi_q    <= 1'b0;
    end else if (req_i) begin
      hi_q <= addr_i[2];
      if (we_i) begin
        rdata_q <= '0;
        rom_q   <= 1'b0;
      end else begin
        rdata_q <= rd64;
        rom_q   <= off[11];
      end
    end
  end

  assign word64 = rom_q ? rom_rdata_i : rdata_q;

  if (BusWidth == 64) begin : g_w64
    assign rdata_o = word64[BusWidth-1:0];
  end else begin : g_w32
    assign rdata_o = BusWidth'(hi_q ? word64[63:32]
                                    : word64[31:0]);
  end

endmodule

// File: tb/tb_dm_mem_mh.sv
// Bench for dm_mem_mh: directed flows plus randomized data,
// read-map and mailbox traffic against a behavioural model.
module tb_dm_mem_mh;

  localparam int NH = 4;
  localparam int PB = 8;
  localparam int DC = 2;
  localparam int AC = 10;
  localparam int HALTED = 'h100;
  localparam int GOING  = 'h108;
  localparam int RESUMING = 'h110;
  localparam int EXCEPT = 'h118;
  localparam int PBBASE = 'h380 - 4 * PB;
  localparam int ACBASE = PBBASE - 4 * AC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni, ndmreset, haltreq, resumereq, clr_ack;
  logic [19:0] hartsel;
  logic [NH-1:0] debug_req, halted, resuming;
  logic [32*PB-1:0] progbuf;
  logic [32*AC-1:0] abscmd;
  logic cmd_valid, cmd_transfer, cmd_postexec, cmd_unsup;
  logic cmdbusy, err_valid;
  logic [2:0] err;
  logic [32*DC-1:0] data_in, data_out;
  logic data_valid, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  logic [63:0] rom;

  logic req64;
  logic [63:0] addr64, rdata64;
  logic [NH-1:0] dr64, h64, r64;
  logic busy64, ev64, dv64;
  logic [2:0] e64;
  logic [32*DC-1:0] do64;

  int total = 0;
  int bad = 0;
  logic [NH-1:0] m_halted, m_res;

  dm_mem_mh dut (
    .clk_i(clk), .rst_ni(rst_ni), .ndmreset_i(ndmreset),
    .hartsel_i(hartsel), .haltreq_i(haltreq),
    .debug_req_o(debug_req), .resumereq_i(resumereq),
    .clear_resumeack_i(clr_ack), .halted_o(halted),
    .resuming_o(resuming), .progbuf_i(progbuf),
    .abscmd_i(abscmd), .cmd_valid_i(cmd_valid),
    .cmd_transfer_i(cmd_transfer),
    .cmd_postexec_i(cmd_postexec),
    .cmd_unsupported_i(cmd_unsup), .cmdbusy_o(cmdbusy),
    .cmderror_valid_o(err_valid), .cmderror_o(err),
    .data_i(data_in), .data_o(data_out),
    .data_valid_o(data_valid), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .rom_rdata_i(rom), .rdata_o(rdata)
  );

  dm_mem_mh #(.BusWidth(64)) u64 (
    .clk_i(clk), .rst_ni(rst_ni), .ndmreset_i(ndmreset),
    .hartsel_i(hartsel), .haltreq_i(haltreq),
    .debug_req_o(dr64), .resumereq_i(resumereq),
    .clear_resumeack_i(clr_ack), .halted_o(h64),
    .resuming_o(r64), .progbuf_i(progbuf),
    .abscmd_i(abscmd), .cmd_valid_i(cmd_valid),
    .cmd_transfer_i(cmd_transfer),
    .cmd_postexec_i(cmd_postexec),
    .cmd_unsupported_i(cmd_unsup), .cmdbusy_o(busy64),
    .cmderror_valid_o(ev64), .cmderror_o(e64),
    .data_i(data_in), .data_o(do64),
    .data_valid_o(dv64), .req_i(req64), .we_i(1'b0),
    .addr_i(addr64), .wdata_i(64'd0), .be_i(8'd0),
    .rom_rdata_i(rom), .rdata_o(rdata64)
  );

  function automatic logic [31:0] jal_enc(input int tgt);
    logic [20:0] i;
    i = 21'(tgt - 'h300);
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'h6f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input int off, input logic [31:0] d);
    req = 1; we = 1; addr = 32'(off); wdata = d; be = 4'hf;
    step();
    req = 0; we = 0;
  endtask

  task automatic mem_rd(input int off, output logic [31:0] d);
    req = 1; we = 0; addr = 32'(off);
    step();
    req = 0;
    d = rdata;
  endtask

  task automatic pulse_cmd(input logic t, input logic p,
                           input logic u);
    cmd_valid = 1; cmd_transfer = t;
    cmd_postexec = p; cmd_unsup = u;
    step();
    cmd_valid = 0; cmd_unsup = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_ni = 0;
    #1;
    total++;
    if (halted !== '0 || cmdbusy !== 0 || err_valid !== 0
        || data_valid !== 0 || rdata !== 0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b/%b/%b/%h exp=0",
               halted, cmdbusy, err_valid, data_valid, rdata);
    end
    step(); step();
    rst_ni = 1;
    step();
    mem_rd('h400, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL reset_flags got=%h exp=0", d);
    end
  endtask

  task automatic test_cmd_flow();
    logic [31:0] d;
    mem_wr(HALTED, 2);
    m_halted[2] = 1;
    total++;
    if (halted !== 4'b0100) begin
      bad++; $display("FAIL halt2 got=%b exp=0100", halted);
    end
    hartsel = 2;
    pulse_cmd(1, 0, 0);
    total++;
    if (cmdbusy !== 1 || err_valid !== 0) begin
      bad++;
      $display("FAIL cmd_go got=%b/%b exp=1/0", cmdbusy, err_valid);
    end
    mem_rd('h400, d);
    total++;
    if (d !== 32'h0001_0000) begin
      bad++; $display("FAIL flags_go got=%h exp=00010000", d);
    end
    mem_rd('h300, d);
    total++;
    if (d !== jal_enc(ACBASE)) begin
      bad++;
      $display("FAIL whereto_abs got=%h exp=%h", d, jal_enc(ACBASE));
    end
    mem_wr(GOING, 0);
    mem_rd('h400, d);
    total++;
    if (cmdbusy !== 1 || d !== 0) begin
      bad++;
      $display("FAIL exec got=%b/%h exp=1/0", cmdbusy, d);
    end
    mem_wr(HALTED, 2);
    total++;
    if (cmdbusy !== 0 || err_valid !== 0) begin
      bad++;
      $display("FAIL cmd_done got=%b/%b exp=0/0", cmdbusy, err_valid);
    end
    pulse_cmd(0, 1, 0);
    mem_rd('h300, d);
    total++;
    if (d !== jal_enc(PBBASE)) begin
      bad++;
      $display("FAIL whereto_pb got=%h exp=%h", d, jal_enc(PBBASE));
    end
    mem_wr(GOING, 0);
    mem_wr(HALTED, 2);
    total++;
    if (cmdbusy !== 0) begin
      bad++; $display("FAIL pb_done got=%b exp=0", cmdbusy);
    end
  endtask

  task automatic test_resume();
    logic [31:0] d;
    mem_wr(HALTED, 1);
    m_halted[1] = 1;
    hartsel = 1;
    resumereq = 1;
    step();
    resumereq = 0;
    mem_rd('h300, d);
    total++;
    if (d !== 32'h5080_006F) begin
      bad++; $display("FAIL whereto_resume got=%h exp=5080006f", d);
    end
    mem_rd('h400, d);
    total++;
    if (d !== 32'h0000_0200) begin
      bad++; $display("FAIL flags_resume got=%h exp=00000200", d);
    end
    mem_wr(RESUMING, 1);
    m_halted[1] = 0; m_res[1] = 1;
    total++;
    if (halted !== m_halted || resuming !== 4'b0010) begin
      bad++;
      $display("FAIL resumed got=%b/%b exp=%b/0010",
               halted, resuming, m_halted);
    end
    mem_rd('h400, d);
    total++;
    if (d !== 0 || cmdbusy !== 0) begin
      bad++; $display("FAIL resume_idle got=%h/%b exp=0/0", d, cmdbusy);
    end
    clr_ack = 1;
    step();
    clr_ack = 0;
    m_res[1] = 0;
    total++;
    if (resuming !== 4'b0000) begin
      bad++; $display("FAIL clr_ack got=%b exp=0000", resuming);
    end
    clr_ack = 1;
    mem_wr(RESUMING, 1);
    clr_ack = 0;
    m_res[1] = 1;
    total++;
    if (resuming !== 4'b0010) begin
      bad++; $display("FAIL set_wins got=%b exp=0010", resuming);
    end
    clr_ack = 1;
    step();
    clr_ack = 0;
    m_res[1] = 0;
  endtask

  task automatic check_err(input string nm, input logic [2:0] code);
    total++;
    if (err_valid !== 1 || err !== code) begin
      bad++;
      $display("FAIL %s got=%b/%0d exp=1/%0d", nm, err_valid, err, code);
    end
    step();
    total++;
    if (err_valid !== 0) begin
      bad++; $display("FAIL %s_pulse got=%b exp=0", nm, err_valid);
    end
  endtask

  task automatic test_errors();
    hartsel = 3;
    pulse_cmd(1, 0, 0);
    check_err("err_nothalt", 4);
    hartsel = 9;
    pulse_cmd(1, 0, 0);
    check_err("err_badhart", 4);
    hartsel = 2;
    pulse_cmd(1, 0, 1);
    check_err("err_unsup", 2);
    total++;
    if (cmdbusy !== 0) begin
      bad++; $display("FAIL unsup_idle got=%b exp=0", cmdbusy);
    end
    pulse_cmd(1, 0, 0);
    pulse_cmd(1, 0, 0);
    check_err("err_busy_go", 1);
    mem_wr(GOING, 0);
    pulse_cmd(1, 0, 0);
    check_err("err_busy_exec", 1);
    total++;
    if (cmdbusy !== 1) begin
      bad++; $display("FAIL busy_kept got=%b exp=1", cmdbusy);
    end
    mem_wr(EXCEPT, 0);
    total++;
    if (cmdbusy !== 0) begin
      bad++; $display("FAIL exc_idle got=%b exp=0", cmdbusy);
    end
    check_err("err_exc", 3);
    resumereq = 1;
    pulse_cmd(1, 0, 0);
    resumereq = 0;
    total++;
    if (cmdbusy !== 1) begin
      bad++; $display("FAIL cmd_wins got=%b exp=1", cmdbusy);
    end
    mem_wr(GOING, 0);
    mem_wr(HALTED, 2);
    for (int h = 0; h < 6; h++) begin
      hartsel = 20'(h);
      haltreq = 1;
      #1;
      total++;
      if (debug_req !== ((h < NH) ? 4'(1 << h) : 4'b0)) begin
        bad++; $display("FAIL debug_req%0d got=%b", h, debug_req);
      end
      haltreq = 0;
    end
  endtask

  task automatic test_data();
    logic [63:0] exp;
    int idx;
    data_in = {32'h1122_3344, 32'h5566_7788};
    req = 1; we = 1; addr = 32'h384;
    wdata = 32'hAABB_CCDD; be = 4'b0011;
    #1;
    total++;
    if (data_out !== {32'h1122_CCDD, 32'h5566_7788}
        || data_valid !== 1) begin
      bad++;
      $display("FAIL data_merge got=%h/%b exp=1122ccdd55667788/1",
               data_out, data_valid);
    end
    step();
    req = 0; we = 0;
    #1;
    total++;
    if (data_valid !== 0 || data_out !== data_in) begin
      bad++;
      $display("FAIL data_idle got=%h/%b", data_out, data_valid);
    end
    for (int n = 0; n < 8; n++) begin
      data_in = {$urandom(), $urandom()};
      idx = $urandom_range(0, DC - 1);
      wdata = $urandom();
      be = 4'($urandom_range(0, 15));
      req = 1; we = 1; addr = 32'('h380 + 4 * idx);
      exp = data_in;
      for (int b = 0; b < 4; b++)
        if (be[b]) exp[32*idx + 8*b +: 8] = wdata[8*b +: 8];
      #1;
      total++;
      if (data_out !== exp || data_valid !== 1) begin
        bad++;
        $display("FAIL data_rand%0d got=%h exp=%h", n, data_out, exp);
      end
      step();
      req = 0; we = 0;
    end
  endtask

  task automatic test_reads();
    logic [31:0] d, exp;
    int off, r, i;
    for (int n = 0; n < PB; n++) progbuf[32*n +: 32] = $urandom();
    for (int n = 0; n < AC; n++) abscmd[32*n +: 32] = $urandom();
    data_in = {$urandom(), $urandom()};
    rom = {$urandom(), $urandom()};
    for (int n = 0; n < 16; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: begin
          i = $urandom_range(0, PB - 1);
          off = PBBASE + 4 * i; exp = progbuf[32*i +: 32];
        end
        1: begin
          i = $urandom_range(0, AC - 1);
          off = ACBASE + 4 * i; exp = abscmd[32*i +: 32];
        end
        2: begin
          i = $urandom_range(0, DC - 1);
          off = 'h380 + 4 * i; exp = data_in[32*i +: 32];
        end
        3: begin
          i = $urandom_range(0, 1);
          off = 'h800 + 8 * $urandom_range(0, 200) + 4 * i;
          exp = rom[32*i +: 32];
        end
        default: begin
          off = 'h200 + 4 * $urandom_range(0, 15); exp = 0;
        end
      endcase
      mem_rd(off, d);
      total++;
      if (d !== exp) begin
        bad++;
        $display("FAIL read%0d off=%h got=%h exp=%h", n, off, d, exp);
      end
    end
    mem_rd(PBBASE, d);
    mem_wr('h204, 32'hffff_ffff);
    total++;
    if (rdata !== 0) begin
      bad++; $display("FAIL wr_rdata got=%h exp=0", rdata);
    end
  endtask

  task automatic test_wide();
    req64 = 1; addr64 = 64'(PBBASE);
    step();
    req64 = 0;
    total++;
    if (rdata64 !== progbuf[63:0]) begin
      bad++;
      $display("FAIL w64_pb got=%h exp=%h", rdata64, progbuf[63:0]);
    end
    req64 = 1; addr64 = 64'h380;
    step();
    req64 = 0;
    total++;
    if (rdata64 !== data_in) begin
      bad++; $display("FAIL w64_data got=%h exp=%h", rdata64, data_in);
    end
    req64 = 1; addr64 = 64'h808;
    step();
    req64 = 0;
    total++;
    if (rdata64 !== rom) begin
      bad++; $display("FAIL w64_rom got=%h exp=%h", rdata64, rom);
    end
  endtask

  task automatic test_mailbox_random();
    int op, id, hs;
    for (int n = 0; n < 24; n++) begin
      op = $urandom_range(0, 2);
      id = $urandom_range(0, 7);
      hs = $urandom_range(0, 5);
      hartsel = 20'(hs);
      clr_ack = 1'($urandom_range(0, 1));
      if (clr_ack && hs < NH) m_res[hs] = 0;
      if (op == 0 && id < NH) m_halted[id] = 1;
      if (op == 1 && id < NH) begin
        m_halted[id] = 0; m_res[id] = 1;
      end
      if (op == 2) step();
      else mem_wr(op == 0 ? HALTED : RESUMING, 32'(id));
      clr_ack = 0;
      total++;
      if (halted !== m_halted || resuming !== m_res) begin
        bad++;
        $display("FAIL mbox%0d got=%b/%b exp=%b/%b",
                 n, halted, resuming, m_halted, m_res);
      end
    end
  endtask

  task automatic test_ndmreset();
    mem_wr(HALTED, 2);
    hartsel = 2;
    pulse_cmd(1, 0, 0);
    mem_wr(GOING, 0);
    total++;
    if (cmdbusy !== 1) begin
      bad++; $display("FAIL ndm_pre got=%b exp=1", cmdbusy);
    end
    ndmreset = 1;
    step();
    ndmreset = 0;
    total++;
    if (halted !== 0 || resuming !== 0 || cmdbusy !== 0
        || err_valid !== 0) begin
      bad++;
      $display("FAIL ndmreset got=%b/%b/%b/%b exp=0",
               halted, resuming, cmdbusy, err_valid);
    end
  endtask

  initial begin
    ndmreset = 0; hartsel = 0; haltreq = 0; resumereq = 0;
    clr_ack = 0; progbuf = '0; abscmd = '0; cmd_valid = 0;
    cmd_transfer = 0; cmd_postexec = 0; cmd_unsup = 0;
    data_in = '0; req = 0; we = 0; addr = 0; wdata = 0;
    be = 0; rom = '0; req64 = 0; addr64 = 0;
    m_halted = '0; m_res = '0;
    test_reset();
    test_cmd_flow();
    test_resume();
    test_errors();
    test_data();
    test_reads();
    test_wide();
    test_mailbox_random();
    test_ndmreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
